// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared FSM state, lane count and output clamp limits for conv_requant_wr
package conv_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int LANES = 4;

  function automatic int out_max(input int ow);
    return (1 << (ow - 1)) - 1;
  endfunction

  function automatic int out_min(input int ow);
    return -(1 << (ow - 1));
  endfunction

  localparam int OUT_MAX = out_max(8);
  localparam int OUT_MIN = out_min(8);

endpackage

// File: rtl/conv_requant_sat.sv
// rtl/conv_requant_sat.sv - combinational round-half-up shift, optional ReLU (CONV_REQUANT_RELU_EN) and clamp
module conv_requant_sat
  import conv_pkg::*;
#(
  parameter int DW = 22,
  parameter int OW = 8
) (
  input  logic [DW-1:0] sum,
  input  logic [4:0]    shift,
  output logic [OW-1:0] q,
  output logic          sat
);

  localparam logic signed [DW:0] HI = (DW+1)'(out_max(OW));
  localparam logic signed [DW:0] LO = (DW+1)'(out_min(OW));

  logic signed [DW:0] ext;
  logic signed [DW:0] rnd;
  logic signed [DW:0] r;

  // One extra bit keeps the rounding add from overflowing before the shift.
  always_comb begin
    ext = {sum[DW-1], sum};
    rnd = (shift != 5'd0) ? ((DW+1)'(1) << (shift - 5'd1)) : '0;
    r   = (ext + rnd) >>> shift;
`ifdef CONV_REQUANT_RELU_EN
    if (r < 0) r = '0;
`endif
    q   = r[OW-1:0];
    sat = 1'b0;
    if (r > HI) begin
      q   = HI[OW-1:0];
      sat = 1'b1;
    end else if (r < LO) begin
      q   = LO[OW-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/conv_requant_wr.sv
// rtl/conv_requant_wr.sv - requantise accumulator sums, pack 4 lanes per word and write out; CONV_REQUANT_RELU_EN enables ReLU
module conv_requant_wr
  import conv_pkg::*;
#(
  parameter int DW = 22,
  parameter int AW = 8,
  parameter int OW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [10:0]         size,
  input  logic [4:0]          shift,
  input  logic [AW-1:0]       base_out,
  input  logic [DW-1:0]       s_sum,
  input  logic                s_valid,
  output logic [AW-1:0]       w_addr,
  output logic [LANES*OW-1:0] w_data,
  output logic                w_en,
  output logic                busy,
  output logic                done,
  output logic                sat
);

  localparam int WW = LANES * OW;

  state_t        state;
  logic [10:0]   size_q;
  logic [10:0]   cnt;
  logic [4:0]    shift_q;
  logic [AW-1:0] addr_q;
  logic          p_valid;
  logic          p_last;
  logic [1:0]    p_lane;
  logic [OW-1:0] p_val;
  logic [WW-1:0] pack;
  logic [WW-1:0] word_nxt;
  logic [OW-1:0] rq_val;
  logic          rq_sat;
  logic          take;

  conv_requant_sat #(.DW(DW), .OW(OW)) u_sat (
    .sum   (s_sum),
    .shift (shift_q),
    .q     (rq_val),
    .sat   (rq_sat)
  );

  assign take = (state == S_RUN) && s_valid;

  // Lane 0 starts a fresh word, so lanes never filled stay zero.
  always_comb begin
    word_nxt = (p_lane == 2'd0) ? '0 : pack;
    word_nxt[p_lane*OW +: OW] = p_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      size_q  <= '0;
      cnt     <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      p_lane  <= '0;
      p_val   <= '0;
      pack    <= '0;
      w_addr  <= '0;
      w_data  <= '0;
      w_en    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sat     <= 1'b0;
    end else begin
      w_en    <= 1'b0;
      busy    <= (state != S_IDLE);
      done    <= (state == S_DONE);
      p_valid <= take;

      if (take) begin
        p_val  <= rq_val;
        p_lane <= cnt[1:0];
        p_last <= (cnt == size_q - 11'd1);
        cnt    <= cnt + 11'd1;
        if (rq_sat) sat <= 1'b1;
      end

      if (p_valid) begin
        pack <= word_nxt;
        if (p_lane == 2'(LANES - 1) || p_last) begin
          w_en   <= 1'b1;
          w_data <= word_nxt;
          w_addr <= addr_q;
          addr_q <= addr_q + 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            size_q  <= size;
            shift_q <= shift;
            addr_q  <= base_out;
            cnt     <= '0;
            sat     <= 1'b0;
            state   <= (size == 11'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (take && cnt == size_q - 11'd1) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (p_valid && p_last) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_requant_wr.sv
// tb/tb_conv_requant_wr.sv - table-driven and randomized checks of conv_requant_wr against a word-level model
module tb_conv_requant_wr;

  logic        clk = 1'b0;
  logic        rst, start, s_valid;
  logic [10:0] size;
  logic [4:0]  shift;
  logic [7:0]  base_out, w_addr;
  logic [21:0] s_sum;
  logic [31:0] w_data;
  logic        w_en, busy, done, sat;

  conv_requant_wr #(.DW(22), .AW(8), .OW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .size(size), .shift(shift),
    .base_out(base_out), .s_sum(s_sum), .s_valid(s_valid), .w_addr(w_addr),
    .w_data(w_data), .w_en(w_en), .busy(busy), .done(done), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct { int a; logic [31:0] d; int c; } wr_t;
  typedef struct {
    int size; int shift; int base; int sums[8];
    int nwords; int a0; int a1; logic [31:0] d0; logic [31:0] d1; bit sat;
  } vec_t;

  int   cyc = 0;
  int   checks = 0, errors = 0;
  wr_t  obs_w[$], exp_w[$];
  int   obs_done[$];
  int   job[$];
  int   gap_pct;
  bit   exp_sat;
  vec_t tbl[4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (w_en) obs_w.push_back('{int'(w_addr), w_data, cyc});
    if (done) obs_done.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference requantiser in plain integer arithmetic.
  function automatic void rq(input longint s, input int sh, output int v, output bit st);
    longint r;
    r = s + ((sh > 0) ? (longint'(1) <<< (sh - 1)) : 0);
    r = r >>> sh;
`ifdef CONV_REQUANT_RELU_EN
    if (r < 0) r = 0;
`endif
    st = 1'b0;
    if (r > 127) begin r = 127; st = 1'b1; end
    else if (r < -128) begin r = -128; st = 1'b1; end
    v = int'(r);
  endfunction

  task automatic run_job(input int n, input int sh, input int base, input bit extra_start);
    logic [31:0] word;
    int v, k, cs, last_wen;
    bit st;
    exp_w.delete(); obs_w.delete(); obs_done.delete();
    exp_sat = 1'b0; word = '0; last_wen = 0;
    start = 1'b1; size = 11'(n); shift = 5'(sh); base_out = 8'(base); cs = cyc;
    tick();
    start = 1'b0;
    k = 0;
    while (k < n) begin
      start = extra_start && (k == 1);
      size  = 11'd0;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        s_sum   = 22'($urandom);
      end else begin
        s_valid = 1'b1;
        s_sum   = 22'(job[k]);
        rq(longint'(job[k]), sh, v, st);
        exp_sat |= st;
        if (k % 4 == 0) word = '0;
        word[(k % 4) * 8 +: 8] = v[7:0];
        if (k % 4 == 3 || k == n - 1) begin
          exp_w.push_back('{(base + k / 4) % 256, word, cyc + 2});
          last_wen = cyc + 2;
        end
        k++;
      end
      tick();
    end
    start = 1'b0; s_valid = 1'b1; s_sum = 22'($urandom);
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 40 && obs_done.size() == 0; i++) tick();
    tick(); tick();
    check("wr_count", obs_w.size(), exp_w.size());
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
      check("wr_addr", obs_w[i].a, exp_w[i].a);
      check("wr_data", obs_w[i].d, exp_w[i].d);
      check("wr_cycle", obs_w[i].c, exp_w[i].c);
    end
    check("done_count", obs_done.size(), 1);
    if (obs_done.size() > 0)
      check("done_cycle", obs_done[0], (n == 0) ? cs + 2 : last_wen + 1);
    check("sat_flag", sat, exp_sat);
    check("busy_after", busy, 0);
  endtask

  initial begin
    int x;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; size = '0; shift = '0; base_out = '0; s_sum = '0;
    gap_pct = 0;

    tbl[0].size = 4; tbl[0].shift = 2; tbl[0].base = 10; tbl[0].sums = '{23, 31, -39, 8, 0, 0, 0, 0};
    tbl[0].nwords = 1; tbl[0].a0 = 10; tbl[0].a1 = 0; tbl[0].d1 = '0; tbl[0].sat = 1'b0;
`ifdef CONV_REQUANT_RELU_EN
    tbl[0].d0 = 32'h0200_0806;
`else
    tbl[0].d0 = 32'h02F6_0806;
`endif
    tbl[1].size = 2; tbl[1].shift = 0; tbl[1].base = 3; tbl[1].sums = '{236, -300, 0, 0, 0, 0, 0, 0};
    tbl[1].nwords = 1; tbl[1].a0 = 3; tbl[1].a1 = 0; tbl[1].d1 = '0; tbl[1].sat = 1'b1;
`ifdef CONV_REQUANT_RELU_EN
    tbl[1].d0 = 32'h0000_007F;
`else
    tbl[1].d0 = 32'h0000_807F;
`endif
    tbl[2].size = 5; tbl[2].shift = 0; tbl[2].base = 20; tbl[2].sums = '{1, 2, 3, 4, 5, 0, 0, 0};
    tbl[2].nwords = 2; tbl[2].a0 = 20; tbl[2].a1 = 21; tbl[2].d0 = 32'h0403_0201;
    tbl[2].d1 = 32'h0000_0005; tbl[2].sat = 1'b0;
    tbl[3].size = 8; tbl[3].shift = 0; tbl[3].base = 255; tbl[3].sums = '{1, 2, 3, 4, 5, 6, 7, 8};
    tbl[3].nwords = 2; tbl[3].a0 = 255; tbl[3].a1 = 0; tbl[3].d0 = 32'h0403_0201;
    tbl[3].d1 = 32'h0807_0605; tbl[3].sat = 1'b0;

    repeat (3) tick();
    check("rst_w_en", w_en, 0);
    check("rst_w_data", w_data, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sat", sat, 0);
    rst = 1'b0;
    tick();

    for (int t = 0; t < 4; t++) begin
      job.delete();
      for (int i = 0; i < tbl[t].size; i++) job.push_back(tbl[t].sums[i]);
      run_job(tbl[t].size, tbl[t].shift, tbl[t].base, 1'b0);
      check("tbl_nwords", obs_w.size(), tbl[t].nwords);
      if (obs_w.size() > 0) begin
        check("tbl_a0", obs_w[0].a, tbl[t].a0);
        check("tbl_d0", obs_w[0].d, tbl[t].d0);
      end
      if (tbl[t].nwords > 1 && obs_w.size() > 1) begin
        check("tbl_a1", obs_w[1].a, tbl[t].a1);
        check("tbl_d1", obs_w[1].d, tbl[t].d1);
      end
      check("tbl_sat", sat, tbl[t].sat);
      if (t == 1) begin
        repeat (4) tick();
        check("sat_hold", sat, 1);
      end
    end

    job.delete();
    run_job(0, 3, 40, 1'b0);

    // Abort after two of eight elements; rst also competes with a start.
    obs_w.delete(); obs_done.delete();
    start = 1'b1; size = 11'd8; shift = 5'd0; base_out = 8'd50;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin s_valid = 1'b1; s_sum = 22'(i + 1); tick(); end
    rst = 1'b1; start = 1'b1; size = 11'd3;
    tick();
    rst = 1'b0; start = 1'b0;
    check("abort_w_en", w_en, 0);
    check("abort_w_data", w_data, 0);
    check("abort_w_addr", w_addr, 0);
    check("abort_busy", busy, 0);
    check("abort_sat", sat, 0);
    repeat (8) begin s_valid = 1'b1; s_sum = 22'(7); tick(); end
    s_valid = 1'b0;
    check("abort_no_wr", obs_w.size(), 0);
    check("abort_no_done", obs_done.size(), 0);
    job.delete();
    for (int i = 0; i < 6; i++) job.push_back(i * 10 - 20);
    run_job(6, 1, 200, 1'b0);

    for (int r = 0; r < 10; r++) begin
      int n;
      job.delete();
      n = (r == 9) ? 37 : int'($urandom_range(1, 20));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(1) == 1) begin
          x = int'($urandom_range(0, 4000)) - 2000;
        end else begin
          x = int'($urandom_range(0, 32'h3F_FFFF)) - 32'h20_0000;
        end
        job.push_back(x);
      end
      gap_pct = (r % 2 == 0) ? 0 : 30;
      run_job(n, int'($urandom_range(0, 12)), int'($urandom_range(0, 255)), (n > 2) && (r % 3 == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
